regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (reg_write / write_reg / write_data) between two writeback requesters.
  - Requester 0: ALU writeback.
  - Requester 1: memory-load writeback.
- Each requester has a one-entry holding slot and a valid/ready handshake. Full slots compete under round-robin arbitration.
- Exports a per-register pending-write mask for hazard stalling in decode.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 3, register index width.
- NUM_REGS, 2**ADDR_W, number of registers. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a write.
- req0_ready  output  1  requester 0 transfer accepted this edge.
- req0_reg  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write data.
- req1_valid, req1_ready, req1_reg, req1_data: same as above, for requester 1.
- reg_write  output  1  write enable to the register file.
- write_reg  output  ADDR_W  register file write index.
- write_data  output  DATA_W  register file write data.
- grant_id  output  1  slot granted this cycle; valid only when reg_write=1.
- busy_mask  output  NUM_REGS  bit r=1 if any full slot targets register r.
- rd_reg1, rd_reg2  input  ADDR_W  register file read indices, snooped.
- rf_data1, rf_data2  input  DATA_W  raw register file read data.
- fwd_data1, fwd_data2  output  DATA_W  read data delivered to decode.

Behaviour:
- State:
  - slot_full[1:0], slot_reg[i], slot_data[i].
  - last_grant: 1 bit.
- Reset (rst=1 at posedge): slot_full=00, last_grant=1. Slot reg/data are don't-care.
  - Outputs next cycle: reg_write=0, busy_mask=0, req*_ready=1.
  - Reset mid-operation discards held writes; no write reaches the register file.
- Arbitration, combinational from slot state:
  - Neither slot full: reg_write=0, write_reg=0, write_data=0, grant_id=0.
  - Exactly one slot full: grant it.
  - Both slots full: grant ~last_grant. The first tie after reset therefore goes to slot 0.
  - When granted: reg_write=1, write_reg=slot_reg[g], write_data=slot_data[g], grant_id=g.
- At posedge with a grant: last_grant<=g and slot_full[g] clears, unless refilled the same edge.
- Handshake:
  - reqi_ready = ~slot_full[i] | grant[i]. This is combinational; requesters must not make valid depend on ready.
  - Transfer occurs when valid&ready at posedge: slot loads reg/data and slot_full[i]<=1.
  - Grant and refill on the same edge: the slot stays full with the new contents. This sustains one write per cycle per requester when the other is idle.
  - valid=1 while ready=0: the requester holds reg/data stable; no loss, no duplication.
- Latency: transfer at edge N → reg_write high in cycle N+1, at the earliest. Register file commits at edge N+1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1… Worst-case wait is 1 cycle.
- Same destination in both slots: no merging. Both writes commit in grant order, so the later-granted value persists.
- busy_mask = OR over i of (slot_full[i] ? onehot(slot_reg[i]) : 0). Includes the slot being written this cycle.
- Register index 0 is an ordinary register; it is not hardwired to zero.

Optional Feature:
- Macro: REGFILE_WRITE_FORWARD_EN.
- Defined: fwd_data1 = (reg_write && write_reg==rd_reg1) ? write_data : rf_data1. fwd_data2 follows the same rule with rd_reg2. Decode sees the value committing at the end of the current cycle.
- Undefined: fwd_dataN = rf_dataN, a pure pass-through. rd_reg1/rd_reg2 are unused.
- Arbitration and handshake are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with req0_valid=1, req0_reg=3 → reg_write=0 throughout. After release: req0_ready=1, busy_mask=8'h00.
- Single write: req0 valid, reg=5, data=32'hDEADBEEF, at edge N → cycle N+1 shows reg_write=1, write_reg=5, write_data=DEADBEEF, grant_id=0, busy_mask=8'h20. Cycle N+2 shows reg_write=0.
- Tie and round-robin: both valid every cycle with reg0=1/data=A, reg1=2/data=B → grant_id sequence 0,1,0,1. Each requester achieves 1 accept per 2 cycles. No lost or duplicated writes; scoreboard compares.
- Back-pressure: req1 valid alone for 4 consecutive data values 1..4 while req0 is idle → 4 consecutive write cycles with data 1,2,3,4. req1_ready stays 1.
- Reset mid-operation: both slots full (regs 6,7), rst pulsed 1 cycle → neither write occurs, busy_mask=0.
- Forwarding (REGFILE_WRITE_FORWARD_EN defined): slot writes reg 4 = 32'h1234, rd_reg1=4, rf_data1=32'h0 in the same cycle → fwd_data1=32'h1234. Undefined build gives 32'h0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between two writeback
// requesters: slot 0 is ALU writeback, slot 1 is memory-load writeback.
// Each requester owns a one-entry holding slot with a valid/ready handshake.
// Full slots compete under round-robin arbitration. A per-register pending
// write mask is exported so decode can stall on hazards.
//
// Optional build macro: REGFILE_WRITE_FORWARD_EN
//   defined   : read data handed to decode is bypassed from the write port
//               when the register being read is committing this cycle.
//   undefined : read data is a pure pass-through of the register file.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    localparam int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDR_W-1:0]   req0_reg,
    input  logic [DATA_W-1:0]   req0_data,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDR_W-1:0]   req1_reg,
    input  logic [DATA_W-1:0]   req1_data,

    output logic                reg_write,
    output logic [ADDR_W-1:0]   write_reg,
    output logic [DATA_W-1:0]   write_data,
    output logic                grant_id,
    output logic [NUM_REGS-1:0] busy_mask,

    input  logic [ADDR_W-1:0]   rd_reg1,
    input  logic [ADDR_W-1:0]   rd_reg2,
    input  logic [DATA_W-1:0]   rf_data1,
    input  logic [DATA_W-1:0]   rf_data2,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic [DATA_W-1:0]   fwd_data2
);

    // Holding slots: index 0 = ALU, index 1 = memory load.
    logic [1:0]        slot_full;
    logic [ADDR_W-1:0] slot_reg  [2];
    logic [DATA_W-1:0] slot_data [2];
    // Slot granted most recently; a tie goes to the other one.
    logic              last_grant;

    // Requester inputs gathered into vectors so both slots share one code path.
    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_reg  [2];
    logic [DATA_W-1:0] in_data [2];

    logic              grant_valid;
    logic              grant_sel;
    logic [1:0]        grant_vec;
    logic [1:0]        ready_vec;
    logic [1:0]        load_vec;

    assign in_valid   = {req1_valid, req0_valid};
    assign in_reg[0]  = req0_reg;
    assign in_reg[1]  = req1_reg;
    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    // Pick the slot that owns the write port this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        grant_sel = 1'b0;
        unique case (slot_full)
            2'b01:   grant_sel = 1'b0;
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
        grant_valid = |slot_full;
        grant_vec   = grant_valid ? (2'b01 << grant_sel) : 2'b00;
    end

    // A slot can accept when empty, or when it drains through the port this
    // cycle, which lets a lone requester sustain one write per cycle.
    assign ready_vec  = ~slot_full | grant_vec;
    assign load_vec   = in_valid & ready_vec;
    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // Drive the register file write port from the granted slot; idle port is all zero.
    always_comb begin
        reg_write  = grant_valid;
        grant_id   = grant_valid ? grant_sel : 1'b0;
        write_reg  = grant_valid ? slot_reg[grant_sel]  : '0;
        write_data = grant_valid ? slot_data[grant_sel] : '0;
    end

    // Occupancy and round-robin pointer; a refill on the grant edge keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            slot_full  <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            if (grant_valid) begin
                last_grant <= grant_sel;
            end
            for (int i = 0; i < 2; i++) begin
                if (load_vec[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Capture payload on a transfer.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; slot_full alone says whether
        // it is meaningful, and leaving it out of reset keeps the data path lean.
        for (int i = 0; i < 2; i++) begin
            if (load_vec[i]) begin
                slot_reg[i]  <= in_reg[i];
                slot_data[i] <= in_data[i];
            end
        end
    end

    // Pending-write mask for decode; includes the slot being written this cycle.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (slot_full[i]) begin
                busy_mask[slot_reg[i]] = 1'b1;
            end
        end
    end

`ifdef REGFILE_WRITE_FORWARD_EN
    // Bypass the value committing at the end of this cycle to decode.
    always_comb begin
        fwd_data1 = (reg_write && (write_reg == rd_reg1)) ? write_data : rf_data1;
        fwd_data2 = (reg_write && (write_reg == rd_reg2)) ? write_data : rf_data2;
    end
`else
    // Read indices are only needed for bypassing; fold them into a sink here.
    logic unused_rd_regs;
    assign unused_rd_regs = ^{rd_reg1, rd_reg2};

    // Plain pass-through of register file read data.
    always_comb begin
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed stimulus with a scoreboard
// of expected register file writes and a monitor that consumes it.
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2**ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0_valid, req1_valid;
    logic                req0_ready, req1_ready;
    logic [ADDR_W-1:0]   req0_reg, req1_reg;
    logic [DATA_W-1:0]   req0_data, req1_data;
    logic                reg_write;
    logic [ADDR_W-1:0]   write_reg;
    logic [DATA_W-1:0]   write_data;
    logic                grant_id;
    logic [NUM_REGS-1:0] busy_mask;
    logic [ADDR_W-1:0]   rd_reg1, rd_reg2;
    logic [DATA_W-1:0]   rf_data1, rf_data2;
    logic [DATA_W-1:0]   fwd_data1, fwd_data2;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy_mask  (busy_mask),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic              g;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                             input logic g);
        wr_t w;
        w.r = r; w.d = d; w.g = g;
        sb.push_back(w);
    endtask

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    // While rst is high the register file is held in reset too, so writes are ignored.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && reg_write === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg=%0d data=%h grant=%0d expected none",
                             write_reg, write_data, grant_id);
                end else begin
                    w = sb.pop_front();
                    check("write_reg",  DATA_W'(write_reg), DATA_W'(w.r));
                    check("write_data", write_data, w.d);
                    check("grant_id",   DATA_W'(grant_id), DATA_W'(w.g));
                end
            end
        end
    end

    // Offer one write on requester 0; returns after the accepting edge (+1).
    task automatic send0(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                         output int waits);
        req0_valid = 1'b1; req0_reg = r; req0_data = d;
        waits = 0;
        @(negedge clk);
        while (!req0_ready && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        if (!req0_ready) begin
            checks++; errors++;
            $display("FAIL send0_timeout: got ready=0 expected ready=1 within 16 cycles");
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                         output int waits);
        req1_valid = 1'b1; req1_reg = r; req1_data = d;
        waits = 0;
        @(negedge clk);
        while (!req1_ready && waits < 16) begin
            waits++;
            @(negedge clk);
        end
        if (!req1_ready) begin
            checks++; errors++;
            $display("FAIL send1_timeout: got ready=0 expected ready=1 within 16 cycles");
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, DATA_W'(sb.size()), '0);
    endtask

    initial begin
        int w0, w1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 32'h0;
        req1_valid = 1'b0; req1_reg = 3'd0; req1_data = 32'h0;
        rd_reg1 = '0; rd_reg2 = '0; rf_data1 = '0; rf_data2 = '0;

        // Reset held two cycles with requester 0 valid: nothing is captured.
        repeat (2) begin
            @(negedge clk);
            check("rst_reg_write", DATA_W'(reg_write), '0);
            check("rst_busy", DATA_W'(busy_mask), '0);
        end
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready0", DATA_W'(req0_ready), 1);
        check("post_rst_ready1", DATA_W'(req1_ready), 1);
        check("post_rst_busy", DATA_W'(busy_mask), '0);
        check("post_rst_reg_write", DATA_W'(reg_write), '0);

        // Single write: one cycle of latency, then idle port is all zero.
        @(posedge clk); #1;
        expect_wr(3'd5, 32'hDEADBEEF, 1'b0);
        send0(3'd5, 32'hDEADBEEF, w0);
        @(negedge clk);
        check("single_busy", DATA_W'(busy_mask), 32'h20);
        check("single_reg_write", DATA_W'(reg_write), 1);
        @(negedge clk);
        check("single_idle_reg_write", DATA_W'(reg_write), '0);
        check("single_idle_reg", DATA_W'(write_reg), '0);
        check("single_idle_data", write_data, '0);

        // Fresh reset so the first tie goes to slot 0, then both stream.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_wr(3'd1, 32'hA000_0000 + k, 1'b0);
            expect_wr(3'd2, 32'hB000_0000 + k, 1'b1);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) send0(3'd1, 32'hA000_0000 + k, w0);
            end
            begin
                for (int k = 0; k < 3; k++) send1(3'd2, 32'hB000_0000 + k, w1);
            end
        join
        drain("rr_drain");

        // Lone requester 1 streams 1..4 with ready never dropping.
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) expect_wr(3'd2, DATA_W'(k), 1'b1);
        for (int k = 1; k <= 4; k++) begin
            send1(3'd2, DATA_W'(k), w1);
            check("stream_ready_waits", DATA_W'(w1), '0);
        end
        drain("stream_drain");

        // Both slots full, reset pulsed: held writes are discarded.
        @(posedge clk); #1;
        fork
            send0(3'd6, 32'h6666_6666, w0);
            send1(3'd7, 32'h7777_7777, w1);
        join
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy_full", DATA_W'(busy_mask), 32'hC0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", DATA_W'(busy_mask), '0);
        check("midrst_reg_write", DATA_W'(reg_write), '0);
        check("midrst_ready0", DATA_W'(req0_ready), 1);
        @(negedge clk);
        check("midrst_reg_write2", DATA_W'(reg_write), '0);

        // Forwarding of the value committing this cycle.
        @(posedge clk); #1;
        rd_reg1 = 3'd4; rf_data1 = 32'h0;
        rd_reg2 = 3'd3; rf_data2 = 32'h55;
        expect_wr(3'd4, 32'h1234, 1'b0);
        send0(3'd4, 32'h1234, w0);
        @(negedge clk);
`ifdef REGFILE_WRITE_FORWARD_EN
        check("fwd_data1_hit", fwd_data1, 32'h1234);
`else
        check("fwd_data1_hit", fwd_data1, 32'h0);
`endif
        check("fwd_data2_miss", fwd_data2, 32'h55);
        @(negedge clk);
        check("fwd_data1_idle", fwd_data1, 32'h0);

        // Same destination in both slots; last grant was slot 0, so slot 1 goes first.
        @(posedge clk); #1;
        expect_wr(3'd3, 32'h222, 1'b1);
        expect_wr(3'd3, 32'h111, 1'b0);
        fork
            send0(3'd3, 32'h111, w0);
            send1(3'd3, 32'h222, w1);
        join
        @(negedge clk);
        check("samedst_busy", DATA_W'(busy_mask), 32'h08);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
